// File: rtl/ber_window_monitor.sv
// ber_window_monitor
// Counts bit errors (popcount of the received-XOR-expected vector) over a
// window of accepted words. At the end of each window it presents one result
// record on a valid/ready handshake. Single-shot and continuous windows are
// supported.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   start       pulse: begin a measurement from IDLE
//   stop        pulse: end the current window early (final word included)
//   cont        continuous mode, sampled when a result is consumed
//   err_valid   err_word is valid this cycle
//   err_word    error vector, one bit per bit error
//   res_valid   result record available
//   res_ready   consumer accepts the result when res_valid=1
//   res_errors  saturating bit-error count of the window
//   res_words   number of words accepted in the window
//   res_alarm   res_errors >= THRESH
//   res_sat     accumulator saturated during the window
//   busy        high in MEASURE or REPORT
//   overrun     sticky: err_valid dropped while in REPORT
module ber_window_monitor #(
    parameter int DATA_W    = 8,
    parameter int WIN_WORDS = 1024,
    parameter int ERR_W     = 16,
    parameter int THRESH    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              cont,
    input  logic              err_valid,
    input  logic [DATA_W-1:0] err_word,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ERR_W-1:0]  res_errors,
    output logic [31:0]       res_words,
    output logic              res_alarm,
    output logic              res_sat,
    output logic              busy,
    output logic              overrun
);

    localparam int PC_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    // Number of set bits in an error vector.
    function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] vec);
        logic [PC_W-1:0] cnt;
        cnt = {PC_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            cnt = cnt + PC_W'(vec[i]);
        end
        return cnt;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [ERR_W-1:0]   r_acc_err;
    logic [31:0]        r_acc_words;
    logic               r_acc_sat;
    logic               r_res_valid;
    logic [ERR_W-1:0]   r_res_errors;
    logic [31:0]        r_res_words;
    logic               r_res_alarm;
    logic               r_res_sat;
    logic               r_busy;
    logic               r_overrun;

    logic [PC_W-1:0]    w_pop;
    logic [ERR_W:0]     w_sum;
    logic [ERR_W-1:0]   w_err_cand;
    logic [31:0]        w_words_cand;
    logic               w_sat_cand;
    logic               w_end;
    logic               w_acc_clear;
    logic               w_acc_load;
    logic               w_res_load;
    logic               w_res_valid_next;
    logic               w_ov_set;
    logic               w_ov_clr;

    // One extra bit on the sum exposes the carry that signals saturation.
    assign w_pop        = popcount(err_word);
    assign w_sum        = {1'b0, r_acc_err} + (ERR_W + 1)'(w_pop);
    assign w_err_cand   = !err_valid ? r_acc_err :
                          (w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0]);
    assign w_sat_cand   = r_acc_sat | (err_valid & w_sum[ERR_W]);
    assign w_words_cand = err_valid ? (r_acc_words + 32'd1) : r_acc_words;
    // A stop with a simultaneous word still ends the window with that word counted.
    assign w_end        = (err_valid && (w_words_cand == 32'(WIN_WORDS))) || stop;

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_state_next     = r_state;
        w_acc_clear      = 1'b0;
        w_acc_load       = 1'b0;
        w_res_load       = 1'b0;
        w_res_valid_next = r_res_valid;
        w_ov_set         = 1'b0;
        w_ov_clr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_MEASURE;
                    w_acc_clear  = 1'b1;
                    w_ov_clr     = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                w_acc_load = err_valid;
                if (w_end) begin
                    w_state_next     = ST_REPORT;
                    w_res_load       = 1'b1;
                    w_res_valid_next = 1'b1;
                end else begin
                    w_state_next = ST_MEASURE;
                end
            end
            ST_REPORT: begin
                w_ov_set = err_valid;
                if (r_res_valid && res_ready) begin
                    w_res_valid_next = 1'b0;
                    if (cont) begin
                        w_state_next = ST_MEASURE;
                        w_acc_clear  = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_REPORT;
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_res_valid_next = 1'b0;
            end
        endcase
    end

    // Accumulators, result record, status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc_err    <= {ERR_W{1'b0}};
            r_acc_words  <= 32'd0;
            r_acc_sat    <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_errors <= {ERR_W{1'b0}};
            r_res_words  <= 32'd0;
            r_res_alarm  <= 1'b0;
            r_res_sat    <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_acc_clear) begin
                r_acc_err   <= {ERR_W{1'b0}};
                r_acc_words <= 32'd0;
                r_acc_sat   <= 1'b0;
            end else if (w_acc_load) begin
                r_acc_err   <= w_err_cand;
                r_acc_words <= w_words_cand;
                r_acc_sat   <= w_sat_cand;
            end else begin
                r_acc_err   <= r_acc_err;
                r_acc_words <= r_acc_words;
                r_acc_sat   <= r_acc_sat;
            end
            // Alarm and sat are captured with the count, never live.
            if (w_res_load) begin
                r_res_errors <= w_err_cand;
                r_res_words  <= w_words_cand;
                r_res_alarm  <= (w_err_cand >= ERR_W'(THRESH));
                r_res_sat    <= w_sat_cand;
            end else begin
                r_res_errors <= r_res_errors;
                r_res_words  <= r_res_words;
                r_res_alarm  <= r_res_alarm;
                r_res_sat    <= r_res_sat;
            end
            r_res_valid <= w_res_valid_next;
            r_busy      <= (w_state_next != ST_IDLE);
            if (w_ov_clr) begin
                r_overrun <= 1'b0;
            end else if (w_ov_set) begin
                r_overrun <= 1'b1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign res_valid  = r_res_valid;
    assign res_errors = r_res_errors;
    assign res_words  = r_res_words;
    assign res_alarm  = r_res_alarm;
    assign res_sat    = r_res_sat;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_ber_window_monitor.sv
// Directed bench for ber_window_monitor with WIN_WORDS=4, THRESH=5, ERR_W=4,
// DATA_W=8. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, i.e. they reflect the preceding edge.
module tb_ber_window_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, stop, cont, err_valid, res_ready;
    logic [7:0]  err_word;
    logic        res_valid, res_alarm, res_sat, busy, overrun;
    logic [3:0]  res_errors;
    logic [31:0] res_words;

    int checks = 0;
    int errors = 0;

    ber_window_monitor #(
        .DATA_W   (8),
        .WIN_WORDS(4),
        .ERR_W    (4),
        .THRESH   (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .err_valid (err_valid),
        .err_word  (err_word),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_errors(res_errors),
        .res_words (res_words),
        .res_alarm (res_alarm),
        .res_sat   (res_sat),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rec(input string tag, input logic [31:0] e_err, input logic [31:0] e_words,
                             input logic e_alarm, input logic e_sat);
        check({tag, ".valid"}, 32'(res_valid), 32'd1);
        check({tag, ".errors"}, 32'(res_errors), e_err);
        check({tag, ".words"}, res_words, e_words);
        check({tag, ".alarm"}, 32'(res_alarm), 32'(e_alarm));
        check({tag, ".sat"}, 32'(res_sat), 32'(e_sat));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0;
        err_valid = 1'b0; err_word = 8'h00; res_ready = 1'b0;

        // 1: reset state, then idle inputs ignored
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst.valid", 32'(res_valid), 32'd0);
        check("rst.errors", 32'(res_errors), 32'd0);
        check("rst.words", res_words, 32'd0);
        check("rst.alarm_sat", {30'd0, res_alarm, res_sat}, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.overrun", 32'(overrun), 32'd0);
        stop = 1'b1; err_valid = 1'b1; err_word = 8'hFF;
        tick();
        stop = 1'b0; err_valid = 1'b0;
        check("idle.ignore", {30'd0, busy, res_valid}, 32'd0);

        // 2: full window, popcounts 0+1+2+4 = 7
        start = 1'b1; res_ready = 1'b1;
        tick();
        start = 1'b0;
        check("w1.busy", 32'(busy), 32'd1);
        err_valid = 1'b1;
        err_word = 8'h00; tick();
        err_word = 8'h01; tick();
        err_word = 8'h03; tick();
        check("w1.early_valid", 32'(res_valid), 32'd0);
        err_word = 8'hF0; tick();
        err_valid = 1'b0;
        check_rec("w1", 32'd7, 32'd4, 1'b1, 1'b0);
        tick();
        check("w1.after_valid", 32'(res_valid), 32'd0);
        check("w1.after_busy", 32'(busy), 32'd0);
        check("w1.hold_errors", 32'(res_errors), 32'd7);

        // 3: saturation, 8+8+8+0 clamps at 15
        res_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        err_valid = 1'b1;
        err_word = 8'hFF; tick();
        err_word = 8'hFF; tick();
        err_word = 8'hFF; tick();
        err_word = 8'h00; tick();
        err_valid = 1'b0;
        check_rec("sat", 32'd15, 32'd4, 1'b1, 1'b1);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("sat.idle", 32'(busy), 32'd0);

        // stop with zero words; start in REPORT ignored
        start = 1'b1; tick(); start = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;
        check_rec("zero", 32'd0, 32'd0, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        check("zero.start_ign", {30'd0, res_valid, busy}, 32'd3);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("zero.idle", 32'(busy), 32'd0);

        // 4: stop together with the second word
        start = 1'b1; tick(); start = 1'b0;
        err_valid = 1'b1;
        err_word = 8'h01; tick();
        err_word = 8'h02; stop = 1'b1; tick();
        stop = 1'b0;
        err_word = 8'hFF;
        check_rec("stop", 32'd2, 32'd2, 1'b0, 1'b0);

        // 5: backpressure with dropped words, then continuous restart
        tick(); tick(); tick();
        err_valid = 1'b0;
        check_rec("hold", 32'd2, 32'd2, 1'b0, 1'b0);
        check("hold.overrun", 32'(overrun), 32'd1);
        res_ready = 1'b1; cont = 1'b1;
        tick();
        res_ready = 1'b0; cont = 1'b0;
        check("cont.valid", 32'(res_valid), 32'd0);
        check("cont.busy", 32'(busy), 32'd1);
        check("cont.overrun", 32'(overrun), 32'd1);
        err_valid = 1'b1; err_word = 8'h01;
        tick(); tick(); tick(); tick();
        err_valid = 1'b0;
        check_rec("cont", 32'd4, 32'd4, 1'b0, 1'b0);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        check("cont.idle", {30'd0, busy, res_valid}, 32'd0);

        // 6: start clears overrun; reset mid-window discards everything
        start = 1'b1; tick(); start = 1'b0;
        check("ovr.clear", 32'(overrun), 32'd0);
        err_valid = 1'b1;
        err_word = 8'h01; tick();
        err_word = 8'h03; tick();
        err_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid.valid", 32'(res_valid), 32'd0);
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.errors", 32'(res_errors), 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick();
        check("mid.after", {30'd0, busy, res_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ber_window_monitor.md
Name: ber_window_monitor

Overview:
Downstream consumer of the BER test controller. Takes the per-word error vector (received XOR expected) and counts errored bits over a fixed measurement window of words. At the end of each window it presents one result record (bit-error count, word count, threshold alarm) on a valid/ready handshake, for readout logic or a host interface. It supports single-shot and continuous windows.

Parameters:
DATA_W, 8, width of the incoming error vector in bits.
WIN_WORDS, 1024, number of accepted words per window (≥1, < 2^32).
ERR_W, 16, width of the bit-error accumulator and of res_errors.
THRESH, 16, alarm threshold on the bit-error count (ERR_W bits).

Ports:
clock  in  1  system clock; all state on its rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
start  in  1  one-cycle pulse; begins a measurement from IDLE.
stop  in  1  one-cycle pulse; ends the current window early.
cont  in  1  continuous mode; sampled when a result is consumed.
err_valid  in  1  err_word is valid this cycle.
err_word  in  DATA_W  error vector; each 1 bit is one bit error.
res_valid  out  1  result record available.
res_ready  in  1  consumer accepts the result when res_valid=1.
res_errors  out  ERR_W  bit errors in the window, saturating.
res_words  out  32  words accepted in the window.
res_alarm  out  1  res_errors >= THRESH.
res_sat  out  1  accumulator saturated during the window.
busy  out  1  high in MEASURE or REPORT.
overrun  out  1  sticky: err_valid was dropped while in REPORT.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; accumulators=0; res_valid=0; res_errors=0; res_words=0; res_alarm=0; res_sat=0; busy=0; overrun=0.
- FSM states: IDLE, MEASURE, REPORT.
- IDLE:
  - err_valid and stop are ignored.
  - start=1 → MEASURE next cycle, with acc_err=0, acc_words=0, sat=0.
- MEASURE, on each cycle with err_valid=1:
  - acc_err += popcount(err_word), saturating at 2^ERR_W-1; sat is set on clamp.
  - acc_words += 1.
- End of window: the accepted word that makes acc_words==WIN_WORDS, or stop=1.
  - On that edge, latch the results into the res_* registers, set res_valid=1 and move to REPORT.
  - Latency: res_valid is high the cycle after the final word is sampled.
- The final word counts. If stop and err_valid are high in the same cycle, that word is included.
- stop with zero words accepted → REPORT with res_words=0, res_errors=0, res_alarm = (THRESH==0).
- start while in MEASURE or REPORT is ignored.
- res_alarm and res_sat are registered together with res_errors. They are never combinational from the live accumulators.
- REPORT:
  - The res_* outputs are stable while res_valid=1 && res_ready=0.
  - Any err_valid=1 in REPORT is dropped (not counted) and sets overrun. overrun clears only on reset or start-from-IDLE.
  - stop is ignored in REPORT.
- Handshake: transfer occurs on an edge with res_valid=1 && res_ready=1. res_ready with res_valid=0 has no effect.
  - After transfer, cont=1 → MEASURE with the accumulators cleared. Words arriving in the first MEASURE cycle are counted.
  - After transfer, cont=0 → IDLE. res_valid drops to 0; res_* hold their last values.
- busy = (state != IDLE).
- Asynchronous reset mid-window or mid-REPORT discards all partial data immediately. No record is emitted.
- Popcount is purely combinational over DATA_W bits, with sum width clog2(DATA_W+1). The accumulator add is zero-extended to ERR_W+1 for the saturation check.

Test Plan:
All scenarios use the bench overrides WIN_WORDS=4, THRESH=5, ERR_W=4, DATA_W=8.

1. Reset low for 2 cycles, then high, no start → all outputs 0, busy=0.
2. start; words 8'h00, 8'h01, 8'h03, 8'hF0 with err_valid=1 on consecutive cycles; res_ready=1, cont=0.
   - Expect res_valid=1 one cycle after the 4th word, res_errors=7, res_words=4, res_alarm=1, res_sat=0.
   - Expect IDLE after transfer.
3. start; words 8'hFF, 8'hFF, 8'hFF → sum 24 clamps at 15.
   - Expect res_errors=15, res_sat=1 at end of window (4th word 8'h00).
4. start; word 8'h01, then stop together with word 8'h02 → res_words=2, res_errors=2, res_alarm=0.
5. Hold res_ready=0 for 3 cycles with err_valid=1 → res_* stable, overrun=1.
   - Then res_ready=1, cont=1 → MEASURE with counters cleared; next window reports res_words=4 independently.
6. Drive reset=0 mid-window after 2 words → res_valid stays 0, state IDLE, busy=0 on the reset edge.
